// File: rtl/lcd_nibble_driver_pkg.sv
// ----------------------------------------------------------------------------
// lcd_nibble_driver_pkg
//   Shared definitions for the HD44780 4-bit LCD write driver: FSM state
//   encodings, the power-up init ROM, the command constants and the
//   long-wait decode used to pick the post-byte delay.
// ----------------------------------------------------------------------------
package lcd_nibble_driver_pkg;

   // HD44780 command bytes
   localparam logic [7:0] CMD_CLEAR     = 8'h01;
   localparam logic [7:0] CMD_HOME      = 8'h02;
   localparam logic [7:0] CMD_HOME_ALT  = 8'h03;   // home with DB0 set; DB0 is don't-care
   localparam logic [7:0] CMD_FUNC_4BIT = 8'h28;
   localparam logic [7:0] CMD_ENTRY     = 8'h06;
   localparam logic [7:0] CMD_DISP_ON   = 8'h0C;

   localparam int unsigned INIT_ROM_LEN = 8;
   localparam int unsigned ROM_IDX_W    = 4;

   // Top-level sequencer states; the SETUP/PULSE/HOLD strobe lives in lcd_nibble_pulse
   typedef enum logic [2:0] {
      ST_POWERUP,
      ST_INIT,
      ST_IDLE,
      ST_STROBE_HI,
      ST_GAP,
      ST_STROBE_LO,
      ST_WAIT
   } drv_state_e;

   typedef enum logic [1:0] {
      PS_IDLE,
      PS_SETUP,
      PS_PULSE,
      PS_HOLD
   } pulse_state_e;

   // One init ROM entry; single-nibble entries carry their nibble in data[7:4]
   typedef struct packed {
      logic       single;
      logic       long_wait;
      logic [7:0] data;
   } init_entry_t;

   // Byte in flight: only what is still needed after the high nibble is issued
   typedef struct packed {
      logic       rs;
      logic       single;
      logic       long_wait;
      logic [3:0] lo_nib;
   } xfer_t;

   // Clear and home need the long execution delay; data writes never do
   function automatic logic needs_long_wait(input logic rs, input logic [7:0] data);
      return !rs && ((data == CMD_CLEAR) || (data == CMD_HOME) || (data == CMD_HOME_ALT));
   endfunction

   // Power-up sequence: three 0x3 wake-ups, switch to 4-bit, then configure
   function automatic init_entry_t init_rom(input logic [ROM_IDX_W-1:0] idx);
      init_entry_t e;
      case (idx)
         4'd0, 4'd1, 4'd2: e = '{single: 1'b1, long_wait: 1'b1, data: 8'h30};
         4'd3:             e = '{single: 1'b1, long_wait: 1'b0, data: 8'h20};
         4'd4:             e = '{single: 1'b0, long_wait: 1'b0, data: CMD_FUNC_4BIT};
         4'd5:             e = '{single: 1'b0, long_wait: 1'b0, data: CMD_ENTRY};
         4'd6:             e = '{single: 1'b0, long_wait: 1'b0, data: CMD_DISP_ON};
         4'd7:             e = '{single: 1'b0, long_wait: 1'b1, data: CMD_CLEAR};
         default:          e = '{single: 1'b0, long_wait: 1'b0, data: 8'h00};
      endcase
      return e;
   endfunction

endpackage

// File: rtl/lcd_nibble_pulse.sv
// ----------------------------------------------------------------------------
// lcd_nibble_pulse
//   Performs one LCD nibble strobe: SETUP (1 cycle, bus driven, E low),
//   PULSE (E high while the shared counter runs), HOLD (1 cycle, E low).
//   The pulse length counter is owned by the parent; this block only
//   requests the load and watches for the last count.
// Ports
//   clk_i, rst_ni      clock, async active-low reset
//   start_i            begin a strobe (sampled in PS_IDLE only)
//   rs_i, nibble_i     register select / nibble captured with start_i
//   cnt_last_i         shared counter is on its final cycle
//   cnt_load_c_o       request load of the E pulse length (comb)
//   done_c_o           HOLD cycle, strobe finishing (comb)
//   lcd_e_o, lcd_rs_o, lcd_dat_o   registered LCD bus
// ----------------------------------------------------------------------------
module lcd_nibble_pulse
   import lcd_nibble_driver_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       start_i,
   input  logic       rs_i,
   input  logic [3:0] nibble_i,
   input  logic       cnt_last_i,
   output logic       cnt_load_c_o,
   output logic       done_c_o,
   output logic       lcd_e_o,
   output logic       lcd_rs_o,
   output logic [3:0] lcd_dat_o
);

   pulse_state_e state_q, state_d;
   logic         lcd_e_q, lcd_e_d;
   logic         lcd_rs_q, lcd_rs_d;
   logic [3:0]   lcd_dat_q, lcd_dat_d;

   // State and output registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= PS_IDLE;
         lcd_e_q   <= 1'b0;
         lcd_rs_q  <= 1'b0;
         lcd_dat_q <= 4'h0;
      end else begin
         state_q   <= state_d;
         lcd_e_q   <= lcd_e_d;
         lcd_rs_q  <= lcd_rs_d;
         lcd_dat_q <= lcd_dat_d;
      end
   end

   // Next state; the pulse length is loaded on the way into PS_PULSE
   always_comb begin
      state_d      = state_q;
      cnt_load_c_o = 1'b0;
      case (state_q)
         PS_IDLE:  if (start_i) state_d = PS_SETUP;
         PS_SETUP: begin
            state_d      = PS_PULSE;
            cnt_load_c_o = 1'b1;
         end
         PS_PULSE: if (cnt_last_i) state_d = PS_HOLD;
         PS_HOLD:  state_d = PS_IDLE;
         default:  state_d = PS_IDLE;
      endcase
   end

   // Outputs; RS/DAT only change on entry to SETUP so they are stable around E
   always_comb begin
      lcd_e_d   = (state_d == PS_PULSE);
      lcd_rs_d  = lcd_rs_q;
      lcd_dat_d = lcd_dat_q;
      if ((state_q == PS_IDLE) && start_i) begin
         lcd_rs_d  = rs_i;
         lcd_dat_d = nibble_i;
      end
      done_c_o = (state_q == PS_HOLD);
   end

   assign lcd_e_o   = lcd_e_q;
   assign lcd_rs_o  = lcd_rs_q;
   assign lcd_dat_o = lcd_dat_q;

endmodule

// File: rtl/lcd_nibble_driver.sv
// ----------------------------------------------------------------------------
// lcd_nibble_driver
//   Turns byte-wide LCD command/data writes into HD44780 4-bit bus cycles.
//   Runs the power-up init sequence by itself, then accepts one byte per
//   in_valid/in_ready handshake. All timing is in clock cycles.
// Ports
//   CCLK, RSTN         clock, async active-low reset
//   in_valid/in_ready  byte handshake; in_ready only once init is complete
//   in_rs, in_data     0 = command, 1 = data; byte to write
//   init_done          init sequence finished, sticky until reset
//   LCDE/LCDRS/LCDRW/LCDDAT   LCD bus (DB7..DB4); LCDRW tied low
// ----------------------------------------------------------------------------
module lcd_nibble_driver
   import lcd_nibble_driver_pkg::*;
#(
   parameter int unsigned POWERUP_CYC    = 750000,
   parameter int unsigned LONG_WAIT_CYC  = 205000,
   parameter int unsigned CMD_WAIT_CYC   = 2000,
   parameter int unsigned E_PULSE_CYC    = 12,
   parameter int unsigned NIBBLE_GAP_CYC = 50
) (
   input  logic       CCLK,
   input  logic       RSTN,
   input  logic       in_valid,
   input  logic       in_rs,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       init_done,
   output logic       LCDE,
   output logic       LCDRS,
   output logic       LCDRW,
   output logic [3:0] LCDDAT
);

   localparam int unsigned MAX_AB  = (POWERUP_CYC > LONG_WAIT_CYC) ? POWERUP_CYC : LONG_WAIT_CYC;
   localparam int unsigned MAX_CD  = (CMD_WAIT_CYC > E_PULSE_CYC) ? CMD_WAIT_CYC : E_PULSE_CYC;
   localparam int unsigned MAX_ABCD = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int unsigned MAX_CYC = (MAX_ABCD > NIBBLE_GAP_CYC) ? MAX_ABCD : NIBBLE_GAP_CYC;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

   drv_state_e           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [ROM_IDX_W-1:0] rom_idx_q, rom_idx_d;
   xfer_t                cur_q, cur_d;
   logic                 init_done_q, init_done_d;
   logic                 in_ready_q, in_ready_d;

   logic                 cnt_load_c;
   logic [CNT_W-1:0]     cnt_val_c;
   logic                 cnt_last_c;
   logic [CNT_W-1:0]     wait_val_c;
   logic                 start_c;
   logic                 nib_rs_c;
   logic [3:0]           nib_c;
   logic                 pls_cnt_load_c;
   logic                 pls_done_c;
   init_entry_t          rom_e_c;

   assign rom_e_c    = init_rom(rom_idx_q);
   assign cnt_last_c = (cnt_q <= CNT_W'(1));
   assign wait_val_c = cur_q.long_wait ? CNT_W'(LONG_WAIT_CYC) : CNT_W'(CMD_WAIT_CYC);

   // State, counter and output registers
   always_ff @(posedge CCLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q     <= ST_POWERUP;
         cnt_q       <= '0;
         rom_idx_q   <= '0;
         cur_q       <= '0;
         init_done_q <= 1'b0;
         in_ready_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rom_idx_q   <= rom_idx_d;
         cur_q       <= cur_d;
         init_done_q <= init_done_d;
         in_ready_q  <= in_ready_d;
      end
   end

   // Shared down-counter: a load of N keeps the owning state for N cycles
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_load_c) begin
         cnt_d = cnt_val_c;
      end else if (pls_cnt_load_c) begin
         cnt_d = CNT_W'(E_PULSE_CYC);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Next state: sequences init ROM / accepted bytes through strobe, gap and wait
   always_comb begin
      state_d    = state_q;
      cur_d      = cur_q;
      rom_idx_d  = rom_idx_q;
      cnt_load_c = 1'b0;
      cnt_val_c  = '0;
      start_c    = 1'b0;
      nib_rs_c   = cur_q.rs;
      nib_c      = cur_q.lo_nib;
      case (state_q)
         ST_POWERUP: begin
            // counter is zero only straight out of reset; this cycle counts as the first
            if (cnt_q == '0) begin
               cnt_load_c = 1'b1;
               cnt_val_c  = CNT_W'(POWERUP_CYC - 1);
            end else if (cnt_last_c) begin
               state_d = ST_INIT;
            end
         end
         ST_INIT: begin
            if (rom_idx_q == ROM_IDX_W'(INIT_ROM_LEN)) begin
               state_d = ST_IDLE;
            end else begin
               cur_d     = '{rs: 1'b0, single: rom_e_c.single,
                             long_wait: rom_e_c.long_wait, lo_nib: rom_e_c.data[3:0]};
               start_c   = 1'b1;
               nib_rs_c  = 1'b0;
               nib_c     = rom_e_c.data[7:4];
               rom_idx_d = rom_idx_q + ROM_IDX_W'(1);
               state_d   = ST_STROBE_HI;
            end
         end
         ST_IDLE: begin
            if (in_valid && in_ready_q) begin
               cur_d    = '{rs: in_rs, single: 1'b0,
                            long_wait: needs_long_wait(in_rs, in_data), lo_nib: in_data[3:0]};
               start_c  = 1'b1;
               nib_rs_c = in_rs;
               nib_c    = in_data[7:4];
               state_d  = ST_STROBE_HI;
            end
         end
         ST_STROBE_HI: begin
            if (pls_done_c) begin
               cnt_load_c = 1'b1;
               if (cur_q.single) begin
                  cnt_val_c = wait_val_c;
                  state_d   = ST_WAIT;
               end else begin
                  cnt_val_c = CNT_W'(NIBBLE_GAP_CYC);
                  state_d   = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            if (cnt_last_c) begin
               start_c = 1'b1;
               state_d = ST_STROBE_LO;
            end
         end
         ST_STROBE_LO: begin
            if (pls_done_c) begin
               cnt_load_c = 1'b1;
               cnt_val_c  = wait_val_c;
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_last_c) state_d = init_done_q ? ST_IDLE : ST_INIT;
         end
         default: state_d = ST_POWERUP;
      endcase
   end

   // Registered handshake/status outputs; IDLE is only reachable after init
   always_comb begin
      in_ready_d  = (state_d == ST_IDLE);
      init_done_d = init_done_q | (state_d == ST_IDLE);
   end

   lcd_nibble_pulse u_pulse (
      .clk_i        (CCLK),
      .rst_ni       (RSTN),
      .start_i      (start_c),
      .rs_i         (nib_rs_c),
      .nibble_i     (nib_c),
      .cnt_last_i   (cnt_last_c),
      .cnt_load_c_o (pls_cnt_load_c),
      .done_c_o     (pls_done_c),
      .lcd_e_o      (LCDE),
      .lcd_rs_o     (LCDRS),
      .lcd_dat_o    (LCDDAT)
   );

   assign in_ready  = in_ready_q;
   assign init_done = init_done_q;
   assign LCDRW     = 1'b0;

endmodule
